// File: rtl/rx_intf_arb_pkg.sv
// Shared types and constants for the rx m_axis channel arbiter.
package rx_intf_arb_pkg;

   // Transfer sequencing states; 3-bit encoding leaves room for spare states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GRANT  = 3'd1,
      ST_START  = 3'd2,
      ST_STREAM = 3'd3,
      ST_FLUSH  = 3'd4
   } arb_state_t;

   // Number of cycles the m_axis path is held in reset after a tlast timeout.
   localparam int FLUSH_CYCLES    = 8;
   localparam int FLUSH_CNT_WIDTH = $clog2(FLUSH_CYCLES);
   localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LAST = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);

   // Requester indices: decoded packet stream and raw IQ capture stream.
   localparam logic REQ_PKT = 1'b0;
   localparam logic REQ_IQ  = 1'b1;

endpackage

// File: rtl/rx_intf_rr_arb2.sv
// Combinational two-way pick between the packet and IQ requesters.
// Fixed-priority mode always favours the packet stream; round-robin mode
// breaks a tie in favour of whichever requester did not own the channel last.
module rx_intf_rr_arb2
   import rx_intf_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       last_owner,
   input  logic       prio_mode,
   output logic       valid,
   output logic       winner
);

   // Select the winner from the eligible set.
   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      valid  = |eligible;
      winner = REQ_PKT;
      if (prio_mode) begin
         winner = eligible[0] ? REQ_PKT : REQ_IQ;
      end else if (eligible == 2'b11) begin
         winner = ~last_owner;
      end else begin
         winner = eligible[1] ? REQ_IQ : REQ_PKT;
      end
   end

endmodule

// File: rtl/rx_intf_m_axis_arbiter.sv
// Owns the single rx m_axis DMA channel and shares it between the decoded
// packet stream (requester 0) and the raw IQ capture stream (requester 1).
// Each transfer runs grant -> start pulse -> stream -> completion on tlast;
// a missing tlast is recovered by a timed reset of the m_axis path.
module rx_intf_m_axis_arbiter
   import rx_intf_arb_pkg::*;
#(
   parameter int C_M00_AXIS_TDATA_WIDTH = 64,
   parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
   parameter int TIMEOUT_WIDTH          = 13
) (
   input  logic                              clk,
   input  logic                              rst,

   input  logic                              req0,
   input  logic                              req1,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] req0_num_dma_symbol,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] req1_num_dma_symbol,
   input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] req0_data,
   input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] req1_data,
   input  logic                              req0_data_valid,
   input  logic                              req1_data_valid,
   output logic                              gnt0,
   output logic                              gnt1,

   input  logic                              cfg_prio_mode,
   input  logic                              cfg_timeout_enable,
   input  logic [TIMEOUT_WIDTH-1:0]          cfg_timeout_top,
   input  logic                              tsf_pulse_1M,

   input  logic                              m_axis_tlast,
   output logic                              start_1trans_to_m_axis,
   output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] monitor_num_dma_symbol_to_ps,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_to_m_axis_out,
   output logic                              data_ready_to_m_axis_out,
   output logic                              m_axis_rst,

   output logic                              timeout_pulse,
   output logic                              busy,
   output logic                              owner,
   output logic [15:0]                       grant_cnt0,
   output logic [15:0]                       grant_cnt1
);

   arb_state_t                 state;
   logic [FLUSH_CNT_WIDTH-1:0] flush_cnt;
   logic [TIMEOUT_WIDTH-1:0]   timeout_cnt;
   logic                       timeout_hit;
   logic [1:0]                 eligible;
   logic                       pick_valid;
   logic                       pick_winner;

   // A requester asking for a zero-length transfer is never considered.
   assign eligible[0] = req0 && (req0_num_dma_symbol != '0);
   assign eligible[1] = req1 && (req1_num_dma_symbol != '0);

   // Timeout fires only once the elapsed microseconds strictly exceed the threshold.
   assign timeout_hit = cfg_timeout_enable && (timeout_cnt > cfg_timeout_top);

   assign busy = (state != ST_IDLE);

   rx_intf_rr_arb2 u_pick (
      .eligible   (eligible),
      .last_owner (owner),
      .prio_mode  (cfg_prio_mode),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   // Transfer sequencer with registered strobes, length monitor and counters.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state                        <= ST_IDLE;
         gnt0                         <= 1'b0;
         gnt1                         <= 1'b0;
         start_1trans_to_m_axis       <= 1'b0;
         monitor_num_dma_symbol_to_ps <= '0;
         m_axis_rst                   <= 1'b0;
         timeout_pulse                <= 1'b0;
         owner                        <= REQ_IQ;
         grant_cnt0                   <= 16'd0;
         grant_cnt1                   <= 16'd0;
         timeout_cnt                  <= '0;
         flush_cnt                    <= '0;
      end else begin
         // Single-cycle strobes fall back to 0 unless re-asserted below.
         gnt0                   <= 1'b0;
         gnt1                   <= 1'b0;
         start_1trans_to_m_axis <= 1'b0;
         timeout_pulse          <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state <= ST_GRANT;
                  owner <= pick_winner;
                  gnt0  <= (pick_winner == REQ_PKT);
                  gnt1  <= (pick_winner == REQ_IQ);
                  if (pick_winner == REQ_IQ) begin
                     monitor_num_dma_symbol_to_ps <= req1_num_dma_symbol;
                     grant_cnt1                   <= grant_cnt1 + 16'd1;
                  end else begin
                     monitor_num_dma_symbol_to_ps <= req0_num_dma_symbol;
                     grant_cnt0                   <= grant_cnt0 + 16'd1;
                  end
               end
            end

            ST_GRANT: begin
               state                  <= ST_START;
               start_1trans_to_m_axis <= 1'b1;
            end

            ST_START: begin
               state       <= ST_STREAM;
               timeout_cnt <= '0;
            end

            ST_STREAM: begin
               if (tsf_pulse_1M && (timeout_cnt != '1)) begin
                  timeout_cnt <= timeout_cnt + TIMEOUT_WIDTH'(1);
               end
               // A tlast in the same cycle as the timeout still completes normally.
               if (m_axis_tlast) begin
                  state <= ST_IDLE;
               end else if (timeout_hit) begin
                  state                        <= ST_FLUSH;
                  timeout_pulse                <= 1'b1;
                  m_axis_rst                   <= 1'b1;
                  flush_cnt                    <= '0;
                  monitor_num_dma_symbol_to_ps <= '0;
               end
            end

            ST_FLUSH: begin
               if (flush_cnt == FLUSH_LAST) begin
                  state      <= ST_IDLE;
                  m_axis_rst <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt + FLUSH_CNT_WIDTH'(1);
               end
            end

            default: begin
               state      <= ST_IDLE;
               m_axis_rst <= 1'b0;
            end
         endcase
      end
   end

   // Route the owner's stream to the m_axis master while a transfer is active.
   always_comb begin
      data_to_m_axis_out       = '0;
      data_ready_to_m_axis_out = 1'b0;
      if ((state == ST_GRANT) || (state == ST_START) || (state == ST_STREAM)) begin
         if (owner == REQ_IQ) begin
            data_to_m_axis_out       = req1_data;
            data_ready_to_m_axis_out = req1_data_valid;
         end else begin
            data_to_m_axis_out       = req0_data;
            data_ready_to_m_axis_out = req0_data_valid;
         end
      end
   end

endmodule

// File: tb/tb_rx_intf_m_axis_arbiter.sv
// Self-checking bench for the rx m_axis channel arbiter: a table of
// arbitration vectors, randomized transfers against a transaction-level
// model, and hand-written sequences for reset, timeout and tlast races.
module tb_rx_intf_m_axis_arbiter;

   localparam int DW = 64;
   localparam int NW = 14;
   localparam int TW = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [NW-1:0] req0_num_dma_symbol, req1_num_dma_symbol;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_data_valid, req1_data_valid;
   logic          gnt0, gnt1;
   logic          cfg_prio_mode, cfg_timeout_enable;
   logic [TW-1:0] cfg_timeout_top;
   logic          tsf_pulse_1M;
   logic          m_axis_tlast;
   logic          start_1trans_to_m_axis;
   logic [NW-1:0] monitor_num_dma_symbol_to_ps;
   logic [DW-1:0] data_to_m_axis_out;
   logic          data_ready_to_m_axis_out;
   logic          m_axis_rst;
   logic          timeout_pulse;
   logic          busy;
   logic          owner;
   logic [15:0]   grant_cnt0, grant_cnt1;

   rx_intf_m_axis_arbiter #(
      .C_M00_AXIS_TDATA_WIDTH (DW),
      .MAX_BIT_NUM_DMA_SYMBOL (NW),
      .TIMEOUT_WIDTH          (TW)
   ) dut (
      .clk                          (clk),
      .rst                          (rst),
      .req0                         (req0),
      .req1                         (req1),
      .req0_num_dma_symbol          (req0_num_dma_symbol),
      .req1_num_dma_symbol          (req1_num_dma_symbol),
      .req0_data                    (req0_data),
      .req1_data                    (req1_data),
      .req0_data_valid              (req0_data_valid),
      .req1_data_valid              (req1_data_valid),
      .gnt0                         (gnt0),
      .gnt1                         (gnt1),
      .cfg_prio_mode                (cfg_prio_mode),
      .cfg_timeout_enable           (cfg_timeout_enable),
      .cfg_timeout_top              (cfg_timeout_top),
      .tsf_pulse_1M                 (tsf_pulse_1M),
      .m_axis_tlast                 (m_axis_tlast),
      .start_1trans_to_m_axis       (start_1trans_to_m_axis),
      .monitor_num_dma_symbol_to_ps (monitor_num_dma_symbol_to_ps),
      .data_to_m_axis_out           (data_to_m_axis_out),
      .data_ready_to_m_axis_out     (data_ready_to_m_axis_out),
      .m_axis_rst                   (m_axis_rst),
      .timeout_pulse                (timeout_pulse),
      .busy                         (busy),
      .owner                        (owner),
      .grant_cnt0                   (grant_cnt0),
      .grant_cnt1                   (grant_cnt1)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: who owned the channel last and grants issued.
   int m_last_owner;
   int m_cnt0;
   int m_cnt1;

   typedef struct {
      logic          r0;
      logic          r1;
      logic [NW-1:0] n0;
      logic [NW-1:0] n1;
      logic          prio;
      int            exp_win;   // 0, 1, or 2 for "nobody granted"
      logic [NW-1:0] exp_mon;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      req0 = 1'b0; req1 = 1'b0;
      req0_num_dma_symbol = '0; req1_num_dma_symbol = '0;
      req0_data = '0; req1_data = '0;
      req0_data_valid = 1'b0; req1_data_valid = 1'b0;
      tsf_pulse_1M = 1'b0; m_axis_tlast = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      quiet_inputs();
      tick();
      tick();
      rst = 1'b0;
      m_last_owner = 1;
      m_cnt0 = 0;
      m_cnt1 = 0;
   endtask

   // Arbitration rules stated directly: eligibility, fixed priority, round-robin tie.
   function automatic int model_pick(input logic e0, input logic e1, input logic prio, input int last);
      if (!e0 && !e1) return 2;
      if (e0 && e1) return prio ? 0 : ((last == 0) ? 1 : 0);
      return e0 ? 0 : 1;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, " gnt0"}, 64'(gnt0), 64'(0));
      check({tag, " gnt1"}, 64'(gnt1), 64'(0));
      check({tag, " start"}, 64'(start_1trans_to_m_axis), 64'(0));
      check({tag, " monitor"}, 64'(monitor_num_dma_symbol_to_ps), 64'(0));
      check({tag, " data"}, 64'(data_to_m_axis_out), 64'(0));
      check({tag, " ready"}, 64'(data_ready_to_m_axis_out), 64'(0));
      check({tag, " m_axis_rst"}, 64'(m_axis_rst), 64'(0));
      check({tag, " timeout_pulse"}, 64'(timeout_pulse), 64'(0));
      check({tag, " busy"}, 64'(busy), 64'(0));
      check({tag, " owner"}, 64'(owner), 64'(1));
      check({tag, " grant_cnt0"}, 64'(grant_cnt0), 64'(0));
      check({tag, " grant_cnt1"}, 64'(grant_cnt1), 64'(0));
   endtask

   // Inputs for IDLE cycle N are already applied; checks gnt at N+1, start at
   // N+2, streams for stream_cycles cycles from N+3, then tlast and IDLE.
   task automatic run_grant(input string tag, input int exp_win, input logic [NW-1:0] exp_mon,
                            input int stream_cycles);
      logic [DW-1:0] exp_d;
      logic          exp_v;
      tick();
      check({tag, " gnt0"}, 64'(gnt0), 64'(exp_win == 0));
      check({tag, " gnt1"}, 64'(gnt1), 64'(exp_win == 1));
      if (exp_win == 2) begin
         for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, " idle busy"}, 64'(busy), 64'(0));
            check({tag, " idle gnt"}, 64'(gnt0 | gnt1), 64'(0));
         end
         req0 = 1'b0;
         req1 = 1'b0;
         return;
      end
      m_last_owner = exp_win;
      if (exp_win == 0) m_cnt0++; else m_cnt1++;
      check({tag, " monitor"}, 64'(monitor_num_dma_symbol_to_ps), 64'(exp_mon));
      check({tag, " owner"}, 64'(owner), 64'(exp_win));
      check({tag, " grant_cnt0"}, 64'(grant_cnt0), 64'(m_cnt0[15:0]));
      check({tag, " grant_cnt1"}, 64'(grant_cnt1), 64'(m_cnt1[15:0]));
      // The granted requester drops its request; the other stays pending.
      if (exp_win == 0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      check({tag, " start"}, 64'(start_1trans_to_m_axis), 64'(1));
      check({tag, " busy"}, 64'(busy), 64'(1));
      tick();
      check({tag, " start gone"}, 64'(start_1trans_to_m_axis), 64'(0));
      for (int i = 0; i < stream_cycles; i++) begin
         req0_data = {$urandom, $urandom};
         req1_data = {$urandom, $urandom};
         req0_data_valid = 1'($urandom_range(0, 1));
         req1_data_valid = 1'($urandom_range(0, 1));
         #1;
         exp_d = (exp_win == 1) ? req1_data : req0_data;
         exp_v = (exp_win == 1) ? req1_data_valid : req0_data_valid;
         check({tag, " mux data"}, 64'(data_to_m_axis_out), 64'(exp_d));
         check({tag, " mux valid"}, 64'(data_ready_to_m_axis_out), 64'(exp_v));
         tick();
      end
      m_axis_tlast = 1'b1;
      req0_data_valid = 1'b1;
      req1_data_valid = 1'b1;
      tick();
      m_axis_tlast = 1'b0;
      check({tag, " idle after tlast"}, 64'(busy), 64'(0));
      check({tag, " idle data"}, 64'(data_to_m_axis_out), 64'(0));
      check({tag, " idle ready"}, 64'(data_ready_to_m_axis_out), 64'(0));
   endtask

   // Drive a single grant through to the first STREAM cycle.
   task automatic enter_stream(input logic r, input logic [NW-1:0] n);
      if (r) begin req1 = 1'b1; req1_num_dma_symbol = n; end
      else   begin req0 = 1'b1; req0_num_dma_symbol = n; end
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ticks;
      int rst_len;
      logic seen;
      logic e0, e1;
      int w;

      rst = 1'b1;
      cfg_prio_mode = 1'b0;
      cfg_timeout_enable = 1'b0;
      cfg_timeout_top = '0;
      quiet_inputs();
      do_reset();
      check_idle_outputs("reset");

      // Table: applied from reset, so the first round-robin tie goes to requester 0.
      vecs[0]  = '{1'b1, 1'b1, 14'd3,  14'd5,     1'b0, 0, 14'd3};
      vecs[1]  = '{1'b1, 1'b1, 14'd7,  14'd2,     1'b0, 1, 14'd2};
      vecs[2]  = '{1'b1, 1'b1, 14'd1,  14'd9,     1'b0, 0, 14'd1};
      vecs[3]  = '{1'b1, 1'b1, 14'd4,  14'd6,     1'b1, 0, 14'd4};
      vecs[4]  = '{1'b1, 1'b1, 14'd8,  14'd8,     1'b1, 0, 14'd8};
      vecs[5]  = '{1'b1, 1'b1, 14'd2,  14'd3,     1'b1, 0, 14'd2};
      vecs[6]  = '{1'b0, 1'b1, 14'd0,  14'd0,     1'b0, 2, 14'd0};
      vecs[7]  = '{1'b1, 1'b1, 14'd0,  14'd12,    1'b1, 1, 14'd12};
      vecs[8]  = '{1'b1, 1'b1, 14'd5,  14'd0,     1'b0, 0, 14'd5};
      vecs[9]  = '{1'b0, 1'b1, 14'd0,  14'd16383, 1'b0, 1, 14'd16383};
      vecs[10] = '{1'b1, 1'b1, 14'd1,  14'd1,     1'b0, 0, 14'd1};
      vecs[11] = '{1'b1, 1'b1, 14'd6,  14'd4,     1'b0, 1, 14'd4};
      for (int v = 0; v < 12; v++) begin
         req0 = vecs[v].r0;
         req1 = vecs[v].r1;
         req0_num_dma_symbol = vecs[v].n0;
         req1_num_dma_symbol = vecs[v].n1;
         cfg_prio_mode = vecs[v].prio;
         run_grant($sformatf("vec%0d", v), vecs[v].exp_win, vecs[v].exp_mon, 2);
      end

      // Randomized transfers; pending requests carry over between transfers.
      cfg_timeout_enable = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (!(req0 && req0_num_dma_symbol != '0)) begin
            req0 = 1'($urandom_range(0, 1));
            req0_num_dma_symbol = ($urandom_range(0, 3) == 0) ? '0 : NW'($urandom_range(1, 16383));
         end
         if (!(req1 && req1_num_dma_symbol != '0)) begin
            req1 = 1'($urandom_range(0, 1));
            req1_num_dma_symbol = ($urandom_range(0, 3) == 0) ? '0 : NW'($urandom_range(1, 16383));
         end
         cfg_prio_mode = 1'($urandom_range(0, 1));
         tsf_pulse_1M = 1'($urandom_range(0, 1));
         e0 = req0 && (req0_num_dma_symbol != '0);
         e1 = req1 && (req1_num_dma_symbol != '0);
         w = model_pick(e0, e1, cfg_prio_mode, m_last_owner);
         run_grant($sformatf("rand%0d", t), w,
                   (w == 1) ? req1_num_dma_symbol : req0_num_dma_symbol,
                   $urandom_range(0, 6));
      end
      quiet_inputs();
      cfg_prio_mode = 1'b0;

      // Reset while streaming clears everything on the next cycle.
      enter_stream(1'b1, 14'd9);
      req1_data = 64'hDEAD_BEEF_0123_4567;
      req1_data_valid = 1'b1;
      rst = 1'b1;
      tick();
      check_idle_outputs("rst in stream");
      rst = 1'b0;
      m_last_owner = 1;
      m_cnt0 = 0;
      m_cnt1 = 0;
      quiet_inputs();
      tick();

      // Single packet transfer, tlast 12 cycles after the start pulse.
      req0 = 1'b1;
      req0_num_dma_symbol = 14'd10;
      run_grant("single", 0, 14'd10, 11);
      check("single grant_cnt0", 64'(grant_cnt0), 64'(1));

      // Timeout without tlast: threshold 5 us, ticks every 4 cycles.
      cfg_timeout_enable = 1'b1;
      cfg_timeout_top = TW'(5);
      enter_stream(1'b0, 14'd20);
      ticks = 0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tsf_pulse_1M = ((c % 4) == 3);
         tick();
         if (tsf_pulse_1M) ticks++;
         if (timeout_pulse) seen = 1'b1;
      end
      tsf_pulse_1M = 1'b0;
      check("timeout seen", 64'(seen), 64'(1));
      check("timeout not early", 64'(ticks >= 6), 64'(1));
      check("timeout not late", 64'(ticks <= 7), 64'(1));
      check("flush m_axis_rst", 64'(m_axis_rst), 64'(1));
      check("flush monitor", 64'(monitor_num_dma_symbol_to_ps), 64'(0));
      check("flush data", 64'(data_ready_to_m_axis_out), 64'(0));
      rst_len = m_axis_rst ? 1 : 0;
      for (int c = 0; c < 20 && m_axis_rst; c++) begin
         tick();
         if (c == 0) check("timeout pulse width", 64'(timeout_pulse), 64'(0));
         if (m_axis_rst) rst_len++;
      end
      check("flush length", 64'(rst_len), 64'(8));
      check("idle after flush", 64'(busy), 64'(0));

      // tlast in the same cycle the timeout condition becomes true: tlast wins.
      cfg_timeout_top = TW'(0);
      enter_stream(1'b1, 14'd3);
      tsf_pulse_1M = 1'b1;
      tick();
      tsf_pulse_1M = 1'b0;
      m_axis_tlast = 1'b1;
      tick();
      m_axis_tlast = 1'b0;
      check("race idle", 64'(busy), 64'(0));
      check("race no timeout_pulse", 64'(timeout_pulse), 64'(0));
      check("race no m_axis_rst", 64'(m_axis_rst), 64'(0));
      tick();
      check("race still no m_axis_rst", 64'(m_axis_rst), 64'(0));
      check("race monitor kept", 64'(monitor_num_dma_symbol_to_ps), 64'(3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
